// File: rtl/prog_loader_if.sv
// Word-stream and instruction-memory write bus shared by the program loader
// and its source / memory. The master is the word source side, the slave is
// the loader itself.
interface prog_loader_if;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/prog_loader.sv
// Boot-stage program loader: streams 32-bit words into instruction memory,
// keeps the CPU in reset until the whole program is written, and keeps a
// running XOR checksum of the loaded words.
module prog_loader #(
  parameter int          MEM_DEPTH = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  localparam int         CW        = $clog2(MEM_DEPTH + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [CW-1:0]  len,
  prog_loader_if.slave   bus,
  output logic           cpu_reset,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic [31:0]    checksum
);

  localparam logic [CW-1:0] MAX_LEN = CW'(MEM_DEPTH);
  localparam logic [CW-1:0] ONE     = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD    = 2'd1,
    S_RELEASE = 2'd2,
    S_RUN     = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] len_q, len_d;
  logic [31:0]   sum_q, sum_d;
  logic          err_q, err_d;
  logic          xfer;

  // A word moves only while loading and the source offers one.
  assign xfer = (state_q == S_LOAD) && bus.in_valid;

  // State register: reset aborts any load in progress immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      len_q   <= '0;
      sum_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      len_q   <= len_d;
      sum_q   <= sum_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: start handling, word counting and checksum update.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    len_d   = len_q;
    sum_d   = sum_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE, S_RUN: begin
        if (start) begin
          if (len > MAX_LEN) begin
            // Oversized request is refused; state is left untouched.
            err_d = 1'b1;
          end else begin
            err_d   = 1'b0;
            count_d = '0;
            sum_d   = '0;
            len_d   = len;
            state_d = (len == '0) ? S_RELEASE : S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (xfer) begin
          count_d = count_q + ONE;
          sum_d   = sum_q ^ bus.in_data;
          if ((count_q + ONE) == len_q) state_d = S_RELEASE;
        end
      end
      S_RELEASE: state_d = S_RUN;
      default:   state_d = S_IDLE;
    endcase
  end

  // Outputs: Moore decode of the state, except the write strobe which
  // follows the handshake so memory captures on the transfer edge.
  always_comb begin
    bus.in_ready  = (state_q == S_LOAD);
    bus.mem_we    = xfer;
    bus.mem_addr  = BASE_ADDR + (32'(count_q) << 2);
    bus.mem_wdata = bus.in_data;
    cpu_reset     = (state_q != S_RUN);
    busy          = (state_q == S_LOAD) || (state_q == S_RELEASE);
    done          = (state_q == S_RUN);
    err           = err_q;
    checksum      = sum_q;
  end

endmodule
